// File: rtl/logic_unit_pkg.sv
// Shared op encoding and width helpers for the pipelined logical unit.
// The op encoding matches the {s2,s1,s0} select lines of the 1-bit cell.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_NAND = 3'b010;
  localparam op_t OP_NOR  = 3'b011;
  localparam op_t OP_XOR  = 3'b100;
  localparam op_t OP_BUF  = 3'b101;
  localparam op_t OP_NOT  = 3'b110;
  localparam op_t OP_XNOR = 3'b111;

  // Bits needed to hold a ones count of 0..width inclusive.
  function automatic int unsigned cw_of(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand-issue and result bundle for logic_unit_pipe.
// The slave modport is the unit itself; master is the issue/consume side.
interface logic_unit_pipe_if
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CW = cw_of(WIDTH);

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             use_acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_parity;
  logic [CW-1:0]    out_ones;

  modport slave (
    input  in_valid, op, a, b, use_acc, acc_clr, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_parity, out_ones
  );

  modport master (
    output in_valid, op, a, b, use_acc, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_parity, out_ones
  );

endinterface

// File: rtl/lu_op_slice.sv
// Purely combinational WIDTH-bit bitwise operation selected by op.
// BUF and NOT ignore b.
module lu_op_slice
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = '0;
    unique case (op)
      OP_AND:  res = ea & b;
      OP_OR:   res = ea | b;
      OP_NAND: res = ~(ea & b);
      OP_NOR:  res = ~(ea | b);
      OP_XOR:  res = ea ^ b;
      OP_BUF:  res = ea;
      OP_NOT:  res = ~ea;
      OP_XNOR: res = ~(ea ^ b);
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logical unit with a chaining accumulator.
// Stage 1 registers the op result; stage 2 registers it with zero/parity/ones flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_pipe_if.slave  bus
);

  localparam int unsigned CW = cw_of(WIDTH);

  logic             adv;
  logic             in_fire;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] res;

  logic             v1_q;
  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] acc_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;
  logic             out_parity_q;
  logic [CW-1:0]    out_ones_q;
  logic [CW-1:0]    ones_d;

  // Global stall: both stages move together or not at all.
  assign adv          = ~out_valid_q | bus.out_ready;
  assign in_fire      = bus.in_valid & adv;
  assign bus.in_ready = adv;

  // A same-cycle clear is visible to the op that reads the accumulator.
  assign ea = bus.use_acc ? (bus.acc_clr ? '0 : acc_q) : bus.a;

  lu_op_slice #(
    .WIDTH (WIDTH)
  ) u_op_slice (
    .op  (bus.op),
    .ea  (ea),
    .b   (bus.b),
    .res (res)
  );

  always_comb begin
    ones_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ones_d = ones_d + CW'(r1_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (in_fire) begin
      acc_q <= res;
    end else if (bus.acc_clr) begin
      acc_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      r1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_zero_q   <= 1'b0;
      out_parity_q <= 1'b0;
      out_ones_q   <= '0;
    end else if (adv) begin
      v1_q        <= in_fire;
      out_valid_q <= v1_q;
      if (in_fire) begin
        r1_q <= res;
      end
      // Data and flags only change together, keeping them mutually consistent.
      if (v1_q) begin
        out_data_q   <= r1_q;
        out_zero_q   <= (r1_q == '0);
        out_parity_q <= ^r1_q;
        out_ones_q   <= ones_d;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_parity = out_parity_q;
  assign bus.out_ones   = out_ones_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe at WIDTH=8: directed plan plus random traffic.
module tb_logic_unit_pipe;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] data;
    int           acc_cyc;
    bit           lat;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  logic [W-1:0] acc_m = '0;
  item_t sb[$];

  logic_unit_pipe_if #(.WIDTH(W)) bus ();

  logic_unit_pipe #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return ~(x & y);
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return x;
      3'd6: return ~x;
      default: return ~(x ^ y);
    endcase
  endfunction

  // One cycle of stimulus; the reference model decides acceptance from in_ready.
  task automatic drive(input bit v, input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input bit ua, input bit clr, input bit ordy,
                       input bit lat);
    logic [W-1:0] ea;
    logic [W-1:0] r;
    @(negedge clk);
    bus.in_valid  = v;
    bus.op        = o;
    bus.a         = av;
    bus.b         = bv;
    bus.use_acc   = ua;
    bus.acc_clr   = clr;
    bus.out_ready = ordy;
    #1;
    if (v && bus.in_ready) begin
      ea = ua ? (clr ? '0 : acc_m) : av;
      r  = ref_op(o, ea, bv);
      sb.push_back('{data: r, acc_cyc: cyc + 1, lat: lat});
      acc_m = r;
      n_acc++;
    end else if (clr) begin
      acc_m = '0;
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  // Monitor: samples mid-cycle, pops on every output transfer.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 64'(bus.out_data), 64'hDEAD);
        end else begin
          it = sb.pop_front();
          check("out_data", 64'(bus.out_data), 64'(it.data));
          check("out_zero", 64'(bus.out_zero), 64'(it.data == '0));
          check("out_parity", 64'(bus.out_parity), 64'(^it.data));
          check("out_ones", 64'(bus.out_ones), 64'($countones(it.data)));
          if (it.lat) check("latency", 64'(cyc + 1 - it.acc_cyc), 64'd2);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] first;
    bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.use_acc = 0; bus.acc_clr = 0; bus.out_ready = 1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_ones", 64'(bus.out_ones), 64'd0);
    check("rst_out_zero", 64'(bus.out_zero), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Op sweep, back to back, unstalled.
    for (int o = 0; o < 8; o++) drive(1'b1, 3'(o), 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Chain through accumulator, then clear collision.
    drive(1'b1, 3'd4, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 3'd0, 8'h77, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 3'd4, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 3'd1, 8'hAA, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 3'd5, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

    // Zero / ones flags.
    drive(1'b1, 3'd0, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 3'd5, 8'hFF, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Backpressure: three beats offered, only two fit.
    n_acc = 0;
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd4, 8'(8'h10 + i), 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_accepted", 64'(n_acc), 64'd2);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    first = 8'h11;
    idle(2, 1'b0);
    check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    check("bp_hold_data", 64'(bus.out_data), 64'(first));
    idle(4, 1'b1);

    // Reset mid-stream with two beats in flight.
    drive(1'b1, 3'd1, 8'h81, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 8'h18, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 0;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data", 64'(bus.out_data), 64'd0);
    check("mid_rst_parity", 64'(bus.out_parity), 64'd0);
    check("mid_rst_ones", 64'(bus.out_ones), 64'd0);
    sb.delete();
    acc_m = '0;
    @(negedge clk);
    rst_n = 1;
    idle(4, 1'b1);
    check("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 3'd5, 8'hEE, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Random traffic with random backpressure and clears.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0), 1'b0);
    end

    // Drain with a bounded cycle budget.
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1, 1'b1);
    idle(2, 1'b1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
